// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on hold plus debounced push-button reset, with the released pulse stretched to a minimum width.
// Latency: s1 reaches btn_level after 2 synchronizer edges plus DEBOUNCE_CYCLES; a btn_level change reaches sys_resetn one edge later.
// Flow control: none; this is a free-running control block with no handshakes.
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset (PLL lock / board reset)
//   s1         in   raw asynchronous push-button
//   sys_resetn out  registered active-low reset for downstream logic
//   btn_level  out  debounced s1
//   rst_state  out  0=POR 1=RUN 2=HOLD 3=STRETCH
//   btn_resets out  saturating count of button-initiated resets
module reset_sequencer #(
  parameter int unsigned POR_CYCLES       = 65535,
  parameter int unsigned DEBOUNCE_CYCLES  = 480000,
  parameter int unsigned MIN_PULSE        = 1024,
  parameter bit          BTN_ACTIVE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       s1,
  output logic       sys_resetn,
  output logic       btn_level,
  output logic [1:0] rst_state,
  output logic [7:0] btn_resets
);

  localparam logic [1:0] ST_POR     = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_STRETCH = 2'd3;

  // A parameter of 1 would give a zero-width counter; keep at least one bit.
  localparam int POR_W = (POR_CYCLES      > 1) ? $clog2(POR_CYCLES)      : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PUL_W = (MIN_PULSE       > 1) ? $clog2(MIN_PULSE)       : 1;

  localparam logic [POR_W-1:0] POR_LOAD   = POR_W'(POR_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PUL_W-1:0] PULSE_LOAD = PUL_W'(MIN_PULSE - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn_level;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [POR_W-1:0] r_por_cnt;
  logic [PUL_W-1:0] r_pulse_cnt;
  logic [1:0]       r_state;
  logic             r_sys_resetn;
  logic [7:0]       r_btn_resets;

  logic             w_btn_req;
  logic [1:0]       w_next_state;
  logic             w_btn_inc;

  // Two-flop synchronizer; idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= ~BTN_ACTIVE_LEVEL;
      r_sync2 <= ~BTN_ACTIVE_LEVEL;
    end else begin
      r_sync1 <= s1;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the synchronized level must disagree with btn_level on
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn_level <= ~BTN_ACTIVE_LEVEL;
      r_deb_cnt   <= '0;
    end else if (r_sync2 != r_btn_level) begin
      if (r_deb_cnt == DEB_LAST) begin
        r_btn_level <= r_sync2;
        r_deb_cnt   <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
    end else begin
      r_deb_cnt <= '0;
    end
  end

  assign w_btn_req = (r_btn_level == BTN_ACTIVE_LEVEL);

  always_comb begin
    w_next_state = r_state;
    w_btn_inc    = 1'b0;
    case (r_state)
      ST_POR: begin
        // A button held through power-on keeps the system in POR.
        if (r_por_cnt == '0 && !w_btn_req) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (w_btn_req) begin
          w_next_state = ST_HOLD;
          w_btn_inc    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!w_btn_req) w_next_state = ST_STRETCH;
      end
      default: begin
        // A re-press during the stretch is the same reset event, so no count.
        if (w_btn_req)                w_next_state = ST_HOLD;
        else if (r_pulse_cnt == '0)   w_next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_POR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // POR counter only runs down from reset and parks at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_por_cnt <= POR_LOAD;
    end else if (r_state == ST_POR && r_por_cnt != '0) begin
      r_por_cnt <= r_por_cnt - POR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pulse_cnt <= '0;
    end else if (r_state == ST_HOLD && !w_btn_req) begin
      r_pulse_cnt <= PULSE_LOAD;
    end else if (r_state == ST_STRETCH && !w_btn_req && r_pulse_cnt != '0) begin
      r_pulse_cnt <= r_pulse_cnt - PUL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn_resets <= '0;
    end else if (w_btn_inc && r_btn_resets != 8'hFF) begin
      r_btn_resets <= r_btn_resets + 8'd1;
    end
  end

  // Loaded from the next state so the output edge coincides with entering or
  // leaving RUN; being a flop it cannot glitch high between edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sys_resetn <= 1'b0;
    end else begin
      r_sys_resetn <= (w_next_state == ST_RUN);
    end
  end

  assign sys_resetn = r_sys_resetn;
  assign btn_level  = r_btn_level;
  assign rst_state  = r_state;
  assign btn_resets = r_btn_resets;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scenario tasks for reset_sequencer plus a randomized run against a behavioural model.
// Latency: outputs are sampled 1 time unit after each rising clk edge.
// Flow control: none; stimulus is driven between edges.
module tb_reset_sequencer;

  localparam int POR = 16;
  localparam int DEB = 4;
  localparam int PUL = 8;
  localparam bit ACT = 1'b0;

  logic       clk = 1'b0;
  logic       resetn;
  logic       s1;
  logic       sys_resetn;
  logic       btn_level;
  logic [1:0] rst_state;
  logic [7:0] btn_resets;

  int vectors    = 0;
  int miscompares = 0;

  reset_sequencer #(
    .POR_CYCLES      (POR),
    .DEBOUNCE_CYCLES (DEB),
    .MIN_PULSE       (PUL),
    .BTN_ACTIVE_LEVEL(ACT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s1        (s1),
    .sys_resetn(sys_resetn),
    .btn_level (btn_level),
    .rst_state (rst_state),
    .btn_resets(btn_resets)
  );

  always #5 clk = ~clk;

  // Behavioural model: edges since reset, consecutive disagreeing samples,
  // edges spent stretching. State numbers follow the output encoding.
  int m_state, m_level, m_s1d1, m_s1d2, m_run, m_edges, m_str, m_cnt;

  task automatic model_reset();
    m_state = 0; m_level = !ACT; m_s1d1 = !ACT; m_s1d2 = !ACT;
    m_run = 0; m_edges = 0; m_str = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit req;
    req = (m_level == ACT);
    m_edges++;
    case (m_state)
      0: if (m_edges >= POR && !req) m_state = 1;
      1: if (req) begin m_state = 2; if (m_cnt < 255) m_cnt++; end
      2: if (!req) begin m_state = 3; m_str = 0; end
      default: begin
        if (req) m_state = 2;
        else begin
          m_str++;
          if (m_str == PUL) m_state = 1;
        end
      end
    endcase
    if (m_s1d2 != m_level) begin
      m_run++;
      if (m_run == DEB) begin m_level = m_s1d2; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_s1d2 = m_s1d1;
    m_s1d1 = s1;
  endtask

  task automatic step();
    @(posedge clk);
    if (resetn) model_edge(); else model_reset();
    #1;
  endtask

  task automatic apply_reset(input logic s1_val);
    @(negedge clk);
    resetn = 1'b0;
    s1     = s1_val;
    model_reset();
    step();
    step();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    resetn = 1'b0;
    s1     = 1'b1;
    model_reset();
    step();
    got = {sys_resetn, btn_level, rst_state, btn_resets};
    vectors++;
    if (got !== {1'b0, 1'b1, 2'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_values: got sys=%b lvl=%b st=%0d cnt=%0d want sys=0 lvl=1 st=0 cnt=0",
               sys_resetn, btn_level, rst_state, btn_resets);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Full POR sequence: low for edges 1..POR-1, RUN on edge POR.
  task automatic check_por_sequence(input string tag);
    logic [2:0] got, want;
    for (int e = 1; e <= POR; e++) begin
      step();
      got  = {sys_resetn, rst_state};
      want = (e == POR) ? {1'b1, 2'd1} : {1'b0, 2'd0};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s edge %0d: got sys=%b st=%0d want sys=%b st=%0d",
                 tag, e, got[2], got[1:0], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_power_on();
    apply_reset(1'b1);
    check_por_sequence("power_on");
  endtask

  task automatic test_debounce();
    logic [3:0] got, want;
    s1 = 1'b0;
    repeat (3) step();
    s1 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      vectors++;
      if (btn_level !== 1'b1 || sys_resetn !== 1'b1) begin
        miscompares++;
        $display("FAIL debounce_glitch edge %0d: got lvl=%b sys=%b want lvl=1 sys=1", e, btn_level, sys_resetn);
      end
    end
    s1 = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      got  = {sys_resetn, btn_level, rst_state};
      want = {(e < 7), (e < 6), (e >= 7) ? 2'd2 : 2'd1};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL debounce_press edge %0d: got sys/lvl/st=%b want %b", e, got, want);
      end
    end
    vectors++;
    if (btn_resets !== 8'd1) begin
      miscompares++;
      $display("FAIL debounce_count: got %0d want 1", btn_resets);
    end
  endtask

  task automatic test_stretch();
    logic [3:0] got, want;
    logic [1:0] st;
    s1 = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      st   = (e < 7) ? 2'd2 : (e < 15) ? 2'd3 : 2'd1;
      want = {(e >= 15), (e >= 6), st};
      got  = {sys_resetn, btn_level, rst_state};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL stretch_release edge %0d: got sys/lvl/st=%b want %b", e, got, want);
      end
    end
    s1 = 1'b0;
    repeat (7) step();
    s1 = 1'b1;
    repeat (7) step();
    vectors++;
    if (rst_state !== 2'd3) begin
      miscompares++;
      $display("FAIL stretch_entry: got st=%0d want 3", rst_state);
    end
    s1 = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      vectors++;
      if (sys_resetn !== 1'b0) begin
        miscompares++;
        $display("FAIL stretch_repress_sys edge %0d: got %b want 0", e, sys_resetn);
      end
    end
    vectors++;
    if (rst_state !== 2'd2 || btn_resets !== 8'd2) begin
      miscompares++;
      $display("FAIL stretch_repress: got st=%0d cnt=%0d want st=2 cnt=2", rst_state, btn_resets);
    end
    s1 = 1'b1;
    repeat (15) step();
    vectors++;
    if (rst_state !== 2'd1 || sys_resetn !== 1'b1) begin
      miscompares++;
      $display("FAIL stretch_return: got st=%0d sys=%b want st=1 sys=1", rst_state, sys_resetn);
    end
  endtask

  task automatic test_async_reset();
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (sys_resetn !== 1'b0 || btn_resets !== 8'd0 || rst_state !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset_immediate: got sys=%b cnt=%0d st=%0d want sys=0 cnt=0 st=0",
               sys_resetn, btn_resets, rst_state);
    end
    #2;
    resetn = 1'b1;
    check_por_sequence("async_por");
  endtask

  task automatic test_held_at_por();
    logic [1:0] got, want;
    apply_reset(1'b0);
    for (int e = 1; e <= 40; e++) begin
      step();
      vectors++;
      if (rst_state !== 2'd0 || sys_resetn !== 1'b0) begin
        miscompares++;
        $display("FAIL held_por edge %0d: got st=%0d sys=%b want st=0 sys=0", e, rst_state, sys_resetn);
      end
    end
    s1 = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      got  = {btn_level, sys_resetn};
      want = {(e >= 6), (e >= 7)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL held_release edge %0d: got lvl/sys=%b want %b", e, got, want);
      end
    end
    vectors++;
    if (rst_state !== 2'd1 || btn_resets !== 8'd0) begin
      miscompares++;
      $display("FAIL held_final: got st=%0d cnt=%0d want st=1 cnt=0", rst_state, btn_resets);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    apply_reset(1'b1);
    repeat (POR) step();
    for (int i = 1; i <= 300; i++) begin
      s1 = 1'b0;
      repeat (8) step();
      s1 = 1'b1;
      repeat (16) step();
      exp_cnt = (i < 255) ? i : 255;
      vectors++;
      if (btn_resets !== 8'(exp_cnt) || rst_state !== 2'd1) begin
        miscompares++;
        $display("FAIL saturation press %0d: got cnt=%0d st=%0d want cnt=%0d st=1",
                 i, btn_resets, rst_state, exp_cnt);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    logic [11:0] got, want;
    apply_reset(1'($urandom_range(0, 1)));
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2;
        resetn = 1'b0;
        model_reset();
        #2;
        resetn = 1'b1;
      end
      if (hold == 0) begin
        s1   = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 20);
      end
      hold--;
      step();
      got  = {sys_resetn, btn_level, rst_state, btn_resets};
      want = {(m_state == 1), 1'(m_level), 2'(m_state), 8'(m_cnt)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL random cycle %0d: got sys=%b lvl=%b st=%0d cnt=%0d want sys=%b lvl=%b st=%0d cnt=%0d",
                 n, got[11], got[10], got[9:8], got[7:0], want[11], want[10], want[9:8], want[7:0]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    s1     = 1'b1;
    test_reset();
    test_power_on();
    test_debounce();
    test_stretch();
    test_async_reset();
    test_held_at_por();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
